// File: rtl/trap_ctrl_pkg.sv
// Shared CSR addresses, mstatus bit positions and the captured-request record for trap_ctrl.
package trap_ctrl_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_HI = 12;
  localparam int MSTATUS_MPP_LO = 11;

  // target holds the handler address for a trap, the saved mepc for an mret
  typedef struct packed {
    logic        is_int;
    logic [3:0]  code;
    logic [31:0] pc;
    logic [31:0] target;
    logic [31:0] mstatus;
  } trap_cap_t;

endpackage

// File: rtl/trap_ctrl_if.sv
// Bundle between trap unit / CSR file / fetch and trap_ctrl; slave is the sequencer side.
interface trap_ctrl_if;

  logic        MEM_WAIT;
  logic        TRAP_EN;
  logic        TRAP_IS_INT;
  logic [3:0]  TRAP_CODE;
  logic [31:0] TRAP_PC;
  logic [31:0] TRAP_JMP_TO;
  logic        MRET_EN;
  logic [31:0] MEPC;
  logic [31:0] MSTATUS;
  logic        INT_ALLOW;
  logic        BUSY;
  logic        FLUSH;
  logic        CSR_WREN;
  logic [11:0] CSR_WADDR;
  logic [31:0] CSR_WDATA;
  logic        JMP_DO;
  logic [31:0] JMP_PC;

  modport master (
    output MEM_WAIT, TRAP_EN, TRAP_IS_INT, TRAP_CODE, TRAP_PC, TRAP_JMP_TO,
           MRET_EN, MEPC, MSTATUS,
    input  INT_ALLOW, BUSY, FLUSH, CSR_WREN, CSR_WADDR, CSR_WDATA, JMP_DO, JMP_PC
  );

  modport slave (
    input  MEM_WAIT, TRAP_EN, TRAP_IS_INT, TRAP_CODE, TRAP_PC, TRAP_JMP_TO,
           MRET_EN, MEPC, MSTATUS,
    output INT_ALLOW, BUSY, FLUSH, CSR_WREN, CSR_WADDR, CSR_WDATA, JMP_DO, JMP_PC
  );

endinterface

// File: rtl/trap_ctrl.sv
// Trap/mret sequencer: flush, one CSR write per cycle, then a single redirect.
// Trap reaches JMP_DO 4 cycles after accept, mret 2; MEM_WAIT holds state and suppresses strobes.
module trap_ctrl
  import trap_ctrl_pkg::*;
(
  input  logic           CLK,
  input  logic           RST,
  trap_ctrl_if.slave     bus
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_T_MEPC    = 3'd1;
  localparam logic [2:0] ST_T_MCAUSE  = 3'd2;
  localparam logic [2:0] ST_T_MSTATUS = 3'd3;
  localparam logic [2:0] ST_M_MSTATUS = 3'd4;
  localparam logic [2:0] ST_JUMP      = 3'd5;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    T_MEPC    = ST_T_MEPC,
    T_MCAUSE  = ST_T_MCAUSE,
    T_MSTATUS = ST_T_MSTATUS,
    M_MSTATUS = ST_M_MSTATUS,
    JUMP      = ST_JUMP
  } state_t;

  function automatic logic [31:0] trap_mstatus(input logic [31:0] m);
    logic [31:0] s;
    s                                 = m;
    s[MSTATUS_MPIE]                   = m[MSTATUS_MIE];
    s[MSTATUS_MIE]                    = 1'b0;
    s[MSTATUS_MPP_HI:MSTATUS_MPP_LO]  = 2'b11;
    return s;
  endfunction

  function automatic logic [31:0] mret_mstatus(input logic [31:0] m);
    logic [31:0] s;
    s                                 = m;
    s[MSTATUS_MIE]                    = m[MSTATUS_MPIE];
    s[MSTATUS_MPIE]                   = 1'b1;
    s[MSTATUS_MPP_HI:MSTATUS_MPP_LO]  = 2'b11;
    return s;
  endfunction

  state_t    state;
  state_t    state_nxt;
  trap_cap_t cap;
  logic      acc_trap;
  logic      acc_mret;
  // FLUSH comes from a register so a stall in the first state cannot repeat it
  logic      flush_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      cap     <= '0;
      flush_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      flush_q <= acc_trap | acc_mret;
      if (acc_trap) begin
        cap.is_int  <= bus.TRAP_IS_INT;
        cap.code    <= bus.TRAP_CODE;
        cap.pc      <= bus.TRAP_PC;
        cap.target  <= bus.TRAP_JMP_TO;
        cap.mstatus <= bus.MSTATUS;
      end else if (acc_mret) begin
        cap.target  <= bus.MEPC;
        cap.mstatus <= bus.MSTATUS;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    acc_trap      = 1'b0;
    acc_mret      = 1'b0;
    bus.CSR_WREN  = 1'b0;
    bus.CSR_WADDR = '0;
    bus.CSR_WDATA = '0;
    bus.JMP_DO    = 1'b0;
    bus.JMP_PC    = '0;
    unique case (state)
      IDLE: begin
        if (!bus.MEM_WAIT) begin
          if (bus.TRAP_EN) begin
            acc_trap  = 1'b1;
            state_nxt = T_MEPC;
          end else if (bus.MRET_EN) begin
            acc_mret  = 1'b1;
            state_nxt = M_MSTATUS;
          end
        end
      end
      T_MEPC: begin
        if (!bus.MEM_WAIT) begin
          bus.CSR_WREN  = 1'b1;
          bus.CSR_WADDR = CSR_MEPC;
          bus.CSR_WDATA = cap.pc & ~32'h3;
          state_nxt     = T_MCAUSE;
        end
      end
      T_MCAUSE: begin
        if (!bus.MEM_WAIT) begin
          bus.CSR_WREN  = 1'b1;
          bus.CSR_WADDR = CSR_MCAUSE;
          bus.CSR_WDATA = {cap.is_int, 27'b0, cap.code};
          state_nxt     = T_MSTATUS;
        end
      end
      T_MSTATUS: begin
        if (!bus.MEM_WAIT) begin
          bus.CSR_WREN  = 1'b1;
          bus.CSR_WADDR = CSR_MSTATUS;
          bus.CSR_WDATA = trap_mstatus(cap.mstatus);
          state_nxt     = JUMP;
        end
      end
      M_MSTATUS: begin
        if (!bus.MEM_WAIT) begin
          bus.CSR_WREN  = 1'b1;
          bus.CSR_WADDR = CSR_MSTATUS;
          bus.CSR_WDATA = mret_mstatus(cap.mstatus);
          state_nxt     = JUMP;
        end
      end
      JUMP: begin
        if (!bus.MEM_WAIT) begin
          bus.JMP_DO = 1'b1;
          bus.JMP_PC = cap.target;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.FLUSH     = flush_q;
  assign bus.BUSY      = (state != IDLE);
  assign bus.INT_ALLOW = (state == IDLE) && bus.MSTATUS[MSTATUS_MIE];

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: per-cycle output vectors compared against hand-computed tables.
module tb_trap_ctrl;

  logic CLK;
  logic RST;
  int   checks;
  int   errors;

  trap_ctrl_if bus ();

  trap_ctrl dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // {FLUSH, CSR_WREN, CSR_WADDR, CSR_WDATA, JMP_DO, JMP_PC, BUSY, INT_ALLOW}
  function automatic logic [80:0] outs();
    return {bus.FLUSH, bus.CSR_WREN, bus.CSR_WADDR, bus.CSR_WDATA,
            bus.JMP_DO, bus.JMP_PC, bus.BUSY, bus.INT_ALLOW};
  endfunction

  function automatic logic [80:0] mk(input logic f, input logic w, input logic [11:0] a,
                                     input logic [31:0] d, input logic j, input logic [31:0] p,
                                     input logic b, input logic ia);
    return {f, w, a, d, j, p, b, ia};
  endfunction

  task automatic set_trap(input logic is_int, input logic [3:0] code,
                          input logic [31:0] pc, input logic [31:0] jmp);
    bus.TRAP_IS_INT = is_int;
    bus.TRAP_CODE   = code;
    bus.TRAP_PC     = pc;
    bus.TRAP_JMP_TO = jmp;
  endtask

  task automatic test_reset();
    logic [80:0] obs;
    RST = 1'b1;
    bus.MEM_WAIT = 1'b0; bus.TRAP_EN = 1'b0; bus.MRET_EN = 1'b0;
    set_trap(1'b0, 4'h0, 32'h0, 32'h0);
    bus.MEPC = 32'h0; bus.MSTATUS = 32'h8;
    repeat (2) @(posedge CLK);
    #1;
    @(negedge CLK);
    obs = outs();
    checks++;
    if (obs !== mk(0, 0, 12'h0, 32'h0, 0, 32'h0, 0, 1)) begin
      errors++;
      $display("FAIL reset_mie1 got %h required %h", obs, mk(0, 0, 12'h0, 32'h0, 0, 32'h0, 0, 1));
    end
    bus.MSTATUS = 32'h0;
    #1;
    obs = outs();
    checks++;
    if (obs !== mk(0, 0, 12'h0, 32'h0, 0, 32'h0, 0, 0)) begin
      errors++;
      $display("FAIL reset_mie0 got %h required %h", obs, mk(0, 0, 12'h0, 32'h0, 0, 32'h0, 0, 0));
    end
    @(posedge CLK); #1;
    RST = 1'b0;
  endtask

  task automatic test_exception();
    logic [80:0] exp [6];
    logic [80:0] obs;
    exp[0] = mk(0, 0, 12'h000, 32'h0,    0, 32'h0,    0, 1);
    exp[1] = mk(1, 1, 12'h341, 32'h1004, 0, 32'h0,    1, 0);
    exp[2] = mk(0, 1, 12'h342, 32'h2,    0, 32'h0,    1, 0);
    exp[3] = mk(0, 1, 12'h300, 32'h1880, 0, 32'h0,    1, 0);
    exp[4] = mk(0, 0, 12'h000, 32'h0,    1, 32'h8000, 1, 0);
    exp[5] = mk(0, 0, 12'h000, 32'h0,    0, 32'h0,    0, 1);
    set_trap(1'b0, 4'd2, 32'h0000_1006, 32'h0000_8000);
    bus.MSTATUS = 32'h8;
    bus.TRAP_EN = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      obs = outs();
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL exception cyc N+%0d got %h required %h", i, obs, exp[i]);
      end
      @(posedge CLK); #1;
      if (i == 0) bus.TRAP_EN = 1'b0;
    end
  endtask

  task automatic test_interrupt();
    logic [80:0] exp [6];
    logic [80:0] obs;
    exp[0] = mk(0, 0, 12'h000, 32'h0,         0, 32'h0,    0, 1);
    exp[1] = mk(1, 1, 12'h341, 32'h2000,      0, 32'h0,    1, 0);
    exp[2] = mk(0, 1, 12'h342, 32'h8000_0007, 0, 32'h0,    1, 0);
    exp[3] = mk(0, 1, 12'h300, 32'h1880,      0, 32'h0,    1, 0);
    exp[4] = mk(0, 0, 12'h000, 32'h0,         1, 32'h9000, 1, 0);
    exp[5] = mk(0, 0, 12'h000, 32'h0,         0, 32'h0,    0, 1);
    set_trap(1'b1, 4'd7, 32'h0000_2000, 32'h0000_9000);
    bus.MSTATUS = 32'h8;
    bus.TRAP_EN = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      obs = outs();
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL interrupt cyc N+%0d got %h required %h", i, obs, exp[i]);
      end
      @(posedge CLK); #1;
      if (i == 0) bus.TRAP_EN = 1'b0;
    end
  endtask

  task automatic test_mret();
    logic [80:0] exp [4];
    logic [80:0] obs;
    exp[0] = mk(0, 0, 12'h000, 32'h0,    0, 32'h0,    0, 0);
    exp[1] = mk(1, 1, 12'h300, 32'h1888, 0, 32'h0,    1, 0);
    exp[2] = mk(0, 0, 12'h000, 32'h0,    1, 32'h1004, 1, 0);
    exp[3] = mk(0, 0, 12'h000, 32'h0,    0, 32'h0,    0, 0);
    bus.MEPC    = 32'h0000_1004;
    bus.MSTATUS = 32'h0000_1880;
    bus.MRET_EN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      obs = outs();
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL mret cyc N+%0d got %h required %h", i, obs, exp[i]);
      end
      @(posedge CLK); #1;
      if (i == 0) bus.MRET_EN = 1'b0;
    end
  endtask

  task automatic test_simultaneous();
    logic [80:0] exp [7];
    logic [80:0] obs;
    exp[0] = mk(0, 0, 12'h000, 32'h0,    0, 32'h0,    0, 1);
    exp[1] = mk(1, 1, 12'h341, 32'h3000, 0, 32'h0,    1, 0);
    exp[2] = mk(0, 1, 12'h342, 32'h4,    0, 32'h0,    1, 0);
    exp[3] = mk(0, 1, 12'h300, 32'h1880, 0, 32'h0,    1, 0);
    exp[4] = mk(0, 0, 12'h000, 32'h0,    1, 32'hA000, 1, 0);
    exp[5] = mk(0, 0, 12'h000, 32'h0,    0, 32'h0,    0, 1);
    exp[6] = mk(0, 0, 12'h000, 32'h0,    0, 32'h0,    0, 1);
    set_trap(1'b0, 4'd4, 32'h0000_3000, 32'h0000_A000);
    bus.MSTATUS = 32'h8;
    bus.MEPC    = 32'h0000_5555;
    bus.TRAP_EN = 1'b1;
    bus.MRET_EN = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge CLK);
      obs = outs();
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL simultaneous cyc N+%0d got %h required %h", i, obs, exp[i]);
      end
      @(posedge CLK); #1;
      // a new request held while busy must not disturb the captured one
      if (i == 1) set_trap(1'b1, 4'd9, 32'h7777_0000, 32'h0000_BBBB);
      if (i == 3) begin
        bus.TRAP_EN = 1'b0;
        bus.MRET_EN = 1'b0;
      end
    end
  endtask

  task automatic test_mem_wait();
    logic [80:0] exp [9];
    logic [80:0] obs;
    exp[0] = mk(0, 0, 12'h000, 32'h0,    0, 32'h0,    0, 1);
    exp[1] = mk(1, 1, 12'h341, 32'h1004, 0, 32'h0,    1, 0);
    exp[2] = mk(0, 0, 12'h000, 32'h0,    0, 32'h0,    1, 0);
    exp[3] = mk(0, 0, 12'h000, 32'h0,    0, 32'h0,    1, 0);
    exp[4] = mk(0, 0, 12'h000, 32'h0,    0, 32'h0,    1, 0);
    exp[5] = mk(0, 1, 12'h342, 32'h2,    0, 32'h0,    1, 0);
    exp[6] = mk(0, 1, 12'h300, 32'h1880, 0, 32'h0,    1, 0);
    exp[7] = mk(0, 0, 12'h000, 32'h0,    1, 32'h8000, 1, 0);
    exp[8] = mk(0, 0, 12'h000, 32'h0,    0, 32'h0,    0, 1);
    set_trap(1'b0, 4'd2, 32'h0000_1006, 32'h0000_8000);
    bus.MSTATUS = 32'h8;
    bus.TRAP_EN = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge CLK);
      obs = outs();
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL mem_wait_mcause cyc N+%0d got %h required %h", i, obs, exp[i]);
      end
      @(posedge CLK); #1;
      if (i == 0) bus.TRAP_EN  = 1'b0;
      if (i == 1) bus.MEM_WAIT = 1'b1;
      if (i == 4) bus.MEM_WAIT = 1'b0;
    end
  endtask

  task automatic test_wait_idle();
    logic [80:0] exp [9];
    logic [80:0] obs;
    exp[0] = mk(0, 0, 12'h000, 32'h0,    0, 32'h0,    0, 1);
    exp[1] = mk(0, 0, 12'h000, 32'h0,    0, 32'h0,    0, 1);
    exp[2] = mk(0, 0, 12'h000, 32'h0,    0, 32'h0,    0, 1);
    exp[3] = mk(0, 0, 12'h000, 32'h0,    0, 32'h0,    0, 1);
    exp[4] = mk(1, 1, 12'h341, 32'h4000, 0, 32'h0,    1, 0);
    exp[5] = mk(0, 1, 12'h342, 32'h1,    0, 32'h0,    1, 0);
    exp[6] = mk(0, 1, 12'h300, 32'h1880, 0, 32'h0,    1, 0);
    exp[7] = mk(0, 0, 12'h000, 32'h0,    1, 32'hC000, 1, 0);
    exp[8] = mk(0, 0, 12'h000, 32'h0,    0, 32'h0,    0, 1);
    set_trap(1'b0, 4'd1, 32'h0000_4002, 32'h0000_C000);
    bus.MSTATUS  = 32'h8;
    bus.MEM_WAIT = 1'b1;
    bus.TRAP_EN  = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge CLK);
      obs = outs();
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL mem_wait_idle cyc %0d got %h required %h", i, obs, exp[i]);
      end
      @(posedge CLK); #1;
      if (i == 2) bus.MEM_WAIT = 1'b0;
      if (i == 3) bus.TRAP_EN  = 1'b0;
    end
  endtask

  task automatic test_rst_mid();
    logic [80:0] exp [6];
    logic [80:0] obs;
    exp[0] = mk(0, 0, 12'h000, 32'h0,    0, 32'h0, 0, 1);
    exp[1] = mk(1, 1, 12'h341, 32'h1004, 0, 32'h0, 1, 0);
    exp[2] = mk(0, 1, 12'h342, 32'h2,    0, 32'h0, 1, 0);
    exp[3] = mk(0, 0, 12'h000, 32'h0,    0, 32'h0, 0, 1);
    exp[4] = mk(0, 0, 12'h000, 32'h0,    0, 32'h0, 0, 1);
    exp[5] = mk(0, 0, 12'h000, 32'h0,    0, 32'h0, 0, 1);
    set_trap(1'b0, 4'd2, 32'h0000_1006, 32'h0000_8000);
    bus.MSTATUS = 32'h8;
    bus.TRAP_EN = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      obs = outs();
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL rst_mid cyc N+%0d got %h required %h", i, obs, exp[i]);
      end
      @(posedge CLK); #1;
      if (i == 0) bus.TRAP_EN = 1'b0;
      if (i == 1) RST = 1'b1;
      if (i == 3) RST = 1'b0;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_exception();
    test_interrupt();
    test_mret();
    test_simultaneous();
    test_mem_wait();
    test_wait_idle();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Sequencer that turns a trap request from the pipeline trap unit, or an `mret` from the execute stage, into an ordered series of actions. It flushes the pipeline, writes `mepc`/`mcause`/`mstatus` one CSR write per cycle through the CSR write port, then issues a single redirect jump. It sits between the trap unit, the CSR file and the fetch stage. It also owns the interrupt-permit signal, so no new interrupt is taken while a sequence is in flight.

## Interface
Parameters: none.
- `CLK`  in  1  system clock
- `RST`  in  1  synchronous, active-high reset
- `MEM_WAIT`  in  1  memory stall; freezes all state transitions and CSR writes
- `TRAP_EN`  in  1  trap request from trap unit
- `TRAP_IS_INT`  in  1  1 = interrupt, 0 = exception
- `TRAP_CODE`  in  4  cause code
- `TRAP_PC`  in  32  PC of trapping instruction
- `TRAP_JMP_TO`  in  32  handler address
- `MRET_EN`  in  1  mret retiring
- `MEPC`  in  32  current `mepc` CSR value
- `MSTATUS`  in  32  current `mstatus` CSR value
- `INT_ALLOW`  out  1  interrupt permitted (to trap unit)
- `BUSY`  out  1  sequence in progress; fetch must not issue
- `FLUSH`  out  1  one-cycle pipeline flush
- `CSR_WREN`  out  1  CSR write strobe
- `CSR_WADDR`  out  12  CSR address
- `CSR_WDATA`  out  32  CSR write data
- `JMP_DO`  out  1  one-cycle redirect
- `JMP_PC`  out  32  redirect target

## Operation
- States: `IDLE`, `T_MEPC`, `T_MCAUSE`, `T_MSTATUS`, `M_MSTATUS`, `JUMP`.
- Accept condition is `IDLE && !MEM_WAIT`.
  - On `TRAP_EN`: capture `TRAP_PC`, `TRAP_IS_INT`, `TRAP_CODE`, `TRAP_JMP_TO` and `MSTATUS`, then go to `T_MEPC`.
  - Otherwise, on `MRET_EN`: capture `MEPC` and `MSTATUS`, then go to `M_MSTATUS`.
  - If `TRAP_EN` and `MRET_EN` arrive together, the trap wins and the mret is discarded (it is flushed).
- Requests arriving in any non-IDLE state are ignored. Their sources are cleared by `FLUSH`.
- Trap path:
  - `T_MEPC`: write 0x341 with `pc & ~3`.
  - `T_MCAUSE`: write 0x342 with `{is_int, 27'b0, code}`.
  - `T_MSTATUS`: write 0x300 with the captured mstatus, modified as MPIE(bit7) ← MIE(bit3), MIE ← 0, MPP(12:11) ← 2'b11.
  - `JUMP`: `JMP_PC` = captured handler address.
- Mret path:
  - `M_MSTATUS`: write 0x300 with MIE ← MPIE, MPIE ← 1, MPP ← 2'b11.
  - `JUMP`: `JMP_PC` = captured mepc.
- `FLUSH` = 1 exactly in the first state after accept (`T_MEPC` or `M_MSTATUS`).
- `CSR_WREN` = write-state && `!MEM_WAIT`.
- `JMP_DO` = (`JUMP` && `!MEM_WAIT`); the state then returns to `IDLE`.
- `BUSY` = state ≠ `IDLE`.
- `INT_ALLOW` = `IDLE` && `MSTATUS[3]`.
- `CSR_WADDR`/`CSR_WDATA`/`JMP_PC` are 0 whenever their strobe is low.

## Timing
- Reset: state `IDLE`; all captured registers 0. Outputs: `FLUSH`, `CSR_WREN`, `JMP_DO`, `BUSY` = 0; buses = 0; `INT_ALLOW` = `MSTATUS[3]`.
- Trap accepted in cycle N with no stalls:
  - N+1: `FLUSH`, mepc write
  - N+2: mcause write
  - N+3: mstatus write
  - N+4: `JMP_DO`
  - N+5: `IDLE`, new accept possible
- Mret accepted in cycle N: N+1 `FLUSH` + mstatus write; N+2 `JMP_DO`.
- `MEM_WAIT` high in a write or `JUMP` state holds the state and suppresses the strobe. The action occurs in the first cycle with `MEM_WAIT` low. `FLUSH` is not repeated.
- `RST` mid-sequence returns to `IDLE` next cycle. No further CSR write or jump is emitted.
- Back-to-back trap: the earliest next accept is the cycle after `JUMP` completes.

## Structure
- Shared header holds:
  - CSR address constants `CSR_MSTATUS`=0x300, `CSR_MEPC`=0x341, `CSR_MCAUSE`=0x342;
  - mstatus bit positions MIE=3, MPIE=7, MPP=12:11.
- State encoding is local `localparam`s (3 bits).
- No sub-module. Two local functions compute the trap and mret mstatus images.

## Test plan
- Exception: `TRAP_EN`=1, `IS_INT`=0, code=2, pc=0x0000_1006, jmp=0x0000_8000, `MSTATUS`=0x8 → `FLUSH` at N+1. Writes, in order: 0x341←0x1004, 0x342←0x2, 0x300←0x1880. `JMP_DO`/`JMP_PC`=0x8000 at N+4.
- Interrupt: `IS_INT`=1, code=7 → mcause write 0x8000_0007. `INT_ALLOW` is 0 from N+1 to N+4.
- Mret: `MRET_EN`=1, `MEPC`=0x1004, `MSTATUS`=0x1880 → 0x300←0x1888 at N+1, jump to 0x1004 at N+2.
- Simultaneous `TRAP_EN`+`MRET_EN` → trap sequence only, no mret mstatus write. A `TRAP_EN` while `BUSY` is ignored.
- `MEM_WAIT` held 3 cycles during `T_MCAUSE` → mcause write and all later events delayed by exactly 3 cycles, `FLUSH` is never repeated. The same 3-cycle wait in `IDLE` with `TRAP_EN` high defers the accept.
- `RST` at N+2 of a trap → no mstatus write, no `JMP_DO`. All outputs return to their reset values from N+3.
